// File: rtl/pilha_rpn_pkg.sv
// Shared op codes and internal action encoding for the RPN operand stack.
// No logic; imported by the interface, the stack top and its testbench.
// Op codes are 3 bits; 111 is reserved and behaves as NOP.
package pilha_rpn_pkg;

    localparam int OP_W = 3;

    typedef logic [OP_W-1:0] op_t;

    localparam op_t OP_NOP    = 3'b000;
    localparam op_t OP_PUSH   = 3'b001;
    localparam op_t OP_POP    = 3'b010;
    localparam op_t OP_REDUCE = 3'b011;
    localparam op_t OP_DUP    = 3'b100;
    localparam op_t OP_SWAP   = 3'b101;
    localparam op_t OP_CLEAR  = 3'b110;

    // Decoded, already-legal action applied to the whole entry array
    typedef enum logic [2:0] {
        ACT_HOLD,
        ACT_PUSH,
        ACT_POP,
        ACT_REDUCE,
        ACT_DUP,
        ACT_SWAP,
        ACT_CLEAR
    } act_t;

endpackage

// File: rtl/pilha_rpn_n_if.sv
// Operation strobe in, stack view and status flags out.
// master = keypad/entry side, slave = the stack itself.
// No handshake: one op per cycle is always accepted.
interface pilha_rpn_n_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
);
    import pilha_rpn_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);

    logic             op_en;
    op_t              op;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] top;
    logic [WIDTH-1:0] next;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             err;
    logic             err_sticky;

    modport master (
        output op_en, op, din,
        input  top, next, count, empty, full, err, err_sticky
    );

    modport slave (
        input  op_en, op, din,
        output top, next, count, empty, full, err, err_sticky
    );

endinterface

// File: rtl/pilha_rpn_n_registrador_nb.sv
// WIDTH-bit register with load enable and async active-low clear.
// Latency: q follows d one clock after en is sampled high.
// Backpressure: none; en simply holds the current value when low.
module registrador_nb #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] val_q;
    logic [WIDTH-1:0] val_d;

    always_comb begin
        val_d = en ? d : val_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            val_q <= '0;
        end else begin
            val_q <= val_d;
        end
    end

    assign q = val_q;

endmodule

// File: rtl/pilha_rpn_n.sv
// Parametrised RPN shift stack exposing top/next as ALU operands; DUP/SWAP under PILHA_RPN_DUPSWAP_EN.
// Latency: one cycle, state and flags update on the edge that samples op_en.
// Backpressure: none; illegal ops leave state unchanged and pulse err.
module pilha_rpn_n
    import pilha_rpn_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    pilha_rpn_n_if.slave  bus
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] ent    [DEPTH];
    logic [WIDTH-1:0] ent_d  [DEPTH];
    logic [WIDTH-1:0] ent_dn [DEPTH];
    logic [WIDTH-1:0] ent_up [DEPTH];
    logic             ent_we;

    logic [CW-1:0] count_q, count_d;
    logic          err_q, err_d;
    logic          sticky_q, sticky_d;
    logic          full_w, has1, has2, illegal;
    act_t          act;

    assign full_w = (count_q == CW'(DEPTH));
    assign has1   = (count_q != '0);
    assign has2   = (count_q >= CW'(2));

    // Decode and legality: an illegal op degrades to ACT_HOLD
    always_comb begin
        act      = ACT_HOLD;
        illegal  = 1'b0;
        count_d  = count_q;
        sticky_d = sticky_q;
        err_d    = 1'b0;
        if (bus.op_en) begin
            case (bus.op)
                OP_PUSH: begin
                    if (!full_w) begin act = ACT_PUSH; count_d = count_q + 1'b1; end
                    else illegal = 1'b1;
                end
                OP_POP: begin
                    if (has1) begin act = ACT_POP; count_d = count_q - 1'b1; end
                    else illegal = 1'b1;
                end
                OP_REDUCE: begin
                    if (has2) begin act = ACT_REDUCE; count_d = count_q - 1'b1; end
                    else illegal = 1'b1;
                end
`ifdef PILHA_RPN_DUPSWAP_EN
                OP_DUP: begin
                    if (has1 && !full_w) begin act = ACT_DUP; count_d = count_q + 1'b1; end
                    else illegal = 1'b1;
                end
                OP_SWAP: begin
                    if (has2) act = ACT_SWAP;
                    else illegal = 1'b1;
                end
`else
                OP_DUP:  illegal = 1'b1;
                OP_SWAP: illegal = 1'b1;
`endif
                OP_CLEAR: begin
                    act      = ACT_CLEAR;
                    count_d  = '0;
                    sticky_d = 1'b0;
                end
                default: ;
            endcase
        end
        if (illegal) begin
            err_d    = 1'b1;
            sticky_d = 1'b1;
        end
    end

    // Shifted views: dn[i] = entry above (toward top), up[i] = entry below, zero at the ends
    always_comb begin
        ent_dn[0]       = '0;
        ent_up[DEPTH-1] = '0;
        for (int i = 1; i < DEPTH; i++) begin
            ent_dn[i]   = ent[i-1];
            ent_up[i-1] = ent[i];
        end
    end

    always_comb begin
        ent_we = (act != ACT_HOLD);
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent[i];
            case (act)
                ACT_PUSH:   ent_d[i] = (i == 0) ? bus.din : ent_dn[i];
                ACT_POP:    ent_d[i] = ent_up[i];
                ACT_REDUCE: ent_d[i] = (i == 0) ? bus.din : ent_up[i];
                ACT_DUP:    ent_d[i] = (i == 0) ? ent[0] : ent_dn[i];
                ACT_SWAP: begin
                    if (i == 0)      ent_d[i] = ent[1];
                    else if (i == 1) ent_d[i] = ent[0];
                end
                ACT_CLEAR:  ent_d[i] = '0;
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        registrador_nb #(.WIDTH(WIDTH)) u_reg (
            .clk (clk),
            .rst (rst),
            .en  (ent_we),
            .d   (ent_d[g]),
            .q   (ent[g])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q  <= '0;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            err_q    <= err_d;
            sticky_q <= sticky_d;
        end
    end

    assign bus.top        = ent[0];
    assign bus.next       = ent[1];
    assign bus.count      = count_q;
    assign bus.empty      = (count_q == '0);
    assign bus.full       = full_w;
    assign bus.err        = err_q;
    assign bus.err_sticky = sticky_q;

endmodule

// File: tb/tb_pilha_rpn_n.sv
// Testbench for pilha_rpn_n (WIDTH=8, DEPTH=4): queue-based reference stack feeds
// an expected-snapshot scoreboard compared against the DUT after each clock.
module tb_pilha_rpn_n;
    import pilha_rpn_pkg::*;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [WIDTH-1:0] top;
        logic [WIDTH-1:0] next;
        logic [CW-1:0]    count;
        logic             empty;
        logic             full;
        logic             err;
        logic             sticky;
    } snap_t;

    logic clk;
    logic rst;

    pilha_rpn_n_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    pilha_rpn_n #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0] m_q [$];
    logic             m_sticky = 1'b0;
    snap_t            exp_q [$];
    snap_t            obs_q [$];

    function automatic snap_t model_snap(input logic er);
        snap_t s;
        s.top    = (m_q.size() > 0) ? m_q[0] : '0;
        s.next   = (m_q.size() > 1) ? m_q[1] : '0;
        s.count  = CW'(m_q.size());
        s.empty  = (m_q.size() == 0);
        s.full   = (m_q.size() == DEPTH);
        s.err    = er;
        s.sticky = m_sticky;
        return s;
    endfunction

    function automatic snap_t sample();
        snap_t s;
        s.top    = bus.top;
        s.next   = bus.next;
        s.count  = bus.count;
        s.empty  = bus.empty;
        s.full   = bus.full;
        s.err    = bus.err;
        s.sticky = bus.err_sticky;
        return s;
    endfunction

    // Reference behaviour of one sampled op; returns whether it was illegal
    function automatic logic model_op(input logic en, input op_t op, input logic [WIDTH-1:0] d);
        logic             er;
        logic [WIDTH-1:0] t;
        int               n;
        er = 1'b0;
        n  = m_q.size();
        if (en) begin
            case (op)
                OP_PUSH:   if (n < DEPTH) m_q.push_front(d); else er = 1'b1;
                OP_POP:    if (n >= 1) void'(m_q.pop_front()); else er = 1'b1;
                OP_REDUCE: begin
                    if (n >= 2) begin
                        void'(m_q.pop_front());
                        void'(m_q.pop_front());
                        m_q.push_front(d);
                    end else er = 1'b1;
                end
`ifdef PILHA_RPN_DUPSWAP_EN
                OP_DUP: begin
                    if (n >= 1 && n < DEPTH) begin t = m_q[0]; m_q.push_front(t); end
                    else er = 1'b1;
                end
                OP_SWAP: begin
                    if (n >= 2) begin t = m_q[0]; m_q[0] = m_q[1]; m_q[1] = t; end
                    else er = 1'b1;
                end
`else
                OP_DUP:  er = 1'b1;
                OP_SWAP: er = 1'b1;
`endif
                OP_CLEAR: begin
                    m_q.delete();
                    m_sticky = 1'b0;
                end
                default: ;
            endcase
        end
        if (er) m_sticky = 1'b1;
        return er;
    endfunction

    task automatic step(input logic en, input op_t op, input logic [WIDTH-1:0] d);
        logic er;
        bus.op_en = en;
        bus.op    = op;
        bus.din   = d;
        er = model_op(en, op, d);
        exp_q.push_back(model_snap(er));
        @(posedge clk);
        #1;
        obs_q.push_back(sample());
        bus.op_en = 1'b0;
        bus.op    = OP_NOP;
        bus.din   = '0;
    endtask

    task automatic test_reset();
        snap_t e, o;
        rst = 1'b0;
        bus.op_en = 1'b0;
        bus.op    = OP_NOP;
        bus.din   = '0;
        repeat (2) @(posedge clk);
        #1;
        e = '0;
        e.empty = 1'b1;
        exp_q.push_back(e);
        obs_q.push_back(sample());
        rst = 1'b1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL reset: got top=%h next=%h cnt=%0d e=%b f=%b err=%b st=%b want top=%h next=%h cnt=%0d e=%b f=%b err=%b st=%b",
                         o.top, o.next, o.count, o.empty, o.full, o.err, o.sticky,
                         e.top, e.next, e.count, e.empty, e.full, e.err, e.sticky);
            end
        end
    endtask

    task automatic test_push();
        snap_t e, o;
        int    k = 0;
        step(1'b1, OP_PUSH, 8'h12);
        step(1'b1, OP_PUSH, 8'h34);
        step(1'b0, OP_PUSH, 8'h99);
        step(1'b1, 3'b111,  8'h77);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL push step %0d: got top=%h next=%h cnt=%0d e=%b f=%b err=%b st=%b want top=%h next=%h cnt=%0d e=%b f=%b err=%b st=%b",
                         k, o.top, o.next, o.count, o.empty, o.full, o.err, o.sticky,
                         e.top, e.next, e.count, e.empty, e.full, e.err, e.sticky);
            end
            k++;
        end
    endtask

    task automatic test_overflow_clear();
        snap_t e, o;
        int    k = 0;
        step(1'b1, OP_CLEAR, 8'h00);
        for (int i = 1; i <= 5; i++) step(1'b1, OP_PUSH, 8'(i));
        step(1'b1, OP_NOP, 8'h00);
        step(1'b1, OP_CLEAR, 8'h00);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL overflow_clear step %0d: got top=%h next=%h cnt=%0d e=%b f=%b err=%b st=%b want top=%h next=%h cnt=%0d e=%b f=%b err=%b st=%b",
                         k, o.top, o.next, o.count, o.empty, o.full, o.err, o.sticky,
                         e.top, e.next, e.count, e.empty, e.full, e.err, e.sticky);
            end
            k++;
        end
    endtask

    task automatic test_underflow();
        snap_t e, o;
        int    k = 0;
        step(1'b1, OP_CLEAR,  8'h00);
        step(1'b1, OP_POP,    8'h00);
        step(1'b1, OP_PUSH,   8'h07);
        step(1'b1, OP_REDUCE, 8'hEE);
        step(1'b1, OP_POP,    8'h00);
        step(1'b1, OP_SWAP,   8'h00);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL underflow step %0d: got top=%h next=%h cnt=%0d e=%b f=%b err=%b st=%b want top=%h next=%h cnt=%0d e=%b f=%b err=%b st=%b",
                         k, o.top, o.next, o.count, o.empty, o.full, o.err, o.sticky,
                         e.top, e.next, e.count, e.empty, e.full, e.err, e.sticky);
            end
            k++;
        end
    endtask

    task automatic test_reduce();
        snap_t e, o;
        int    k = 0;
        step(1'b1, OP_CLEAR,  8'h00);
        step(1'b1, OP_PUSH,   8'h03);
        step(1'b1, OP_PUSH,   8'h05);
        step(1'b1, OP_PUSH,   8'h09);
        step(1'b1, OP_REDUCE, 8'h0E);
        step(1'b1, OP_POP,    8'h00);
        step(1'b1, OP_POP,    8'h00);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL reduce step %0d: got top=%h next=%h cnt=%0d e=%b f=%b err=%b st=%b want top=%h next=%h cnt=%0d e=%b f=%b err=%b st=%b",
                         k, o.top, o.next, o.count, o.empty, o.full, o.err, o.sticky,
                         e.top, e.next, e.count, e.empty, e.full, e.err, e.sticky);
            end
            k++;
        end
    endtask

    task automatic test_dupswap();
        snap_t e, o;
        int    k = 0;
        step(1'b1, OP_CLEAR, 8'h00);
        step(1'b1, OP_PUSH,  8'hA1);
        step(1'b1, OP_PUSH,  8'hB2);
        step(1'b1, OP_SWAP,  8'h00);
        step(1'b1, OP_DUP,   8'h00);
        step(1'b1, OP_DUP,   8'h00);
        step(1'b1, OP_DUP,   8'h00);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL dupswap step %0d: got top=%h next=%h cnt=%0d e=%b f=%b err=%b st=%b want top=%h next=%h cnt=%0d e=%b f=%b err=%b st=%b",
                         k, o.top, o.next, o.count, o.empty, o.full, o.err, o.sticky,
                         e.top, e.next, e.count, e.empty, e.full, e.err, e.sticky);
            end
            k++;
        end
    endtask

    task automatic test_async_reset();
        snap_t e, o;
        int    k = 0;
        step(1'b1, OP_CLEAR, 8'h00);
        step(1'b1, OP_POP,   8'h00);
        step(1'b1, OP_PUSH,  8'h55);
        // Mid-cycle assertion: outputs must clear before any further edge
        #2;
        rst = 1'b0;
        #1;
        m_q.delete();
        m_sticky = 1'b0;
        exp_q.push_back(model_snap(1'b0));
        obs_q.push_back(sample());
        bus.op_en = 1'b1;
        bus.op    = OP_PUSH;
        bus.din   = 8'hAA;
        @(posedge clk);
        #1;
        exp_q.push_back(model_snap(1'b0));
        obs_q.push_back(sample());
        bus.op_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, OP_PUSH, 8'h66);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL async_reset step %0d: got top=%h next=%h cnt=%0d e=%b f=%b err=%b st=%b want top=%h next=%h cnt=%0d e=%b f=%b err=%b st=%b",
                         k, o.top, o.next, o.count, o.empty, o.full, o.err, o.sticky,
                         e.top, e.next, e.count, e.empty, e.full, e.err, e.sticky);
            end
            k++;
        end
    endtask

    task automatic test_back_to_back();
        snap_t e, o;
        int    k = 0;
        step(1'b1, OP_CLEAR, 8'h00);
        for (int i = 0; i < 80; i++) begin
            step(($urandom_range(0, 7) != 0), op_t'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL back_to_back step %0d: got top=%h next=%h cnt=%0d e=%b f=%b err=%b st=%b want top=%h next=%h cnt=%0d e=%b f=%b err=%b st=%b",
                         k, o.top, o.next, o.count, o.empty, o.full, o.err, o.sticky,
                         e.top, e.next, e.count, e.empty, e.full, e.err, e.sticky);
            end
            k++;
        end
    endtask

    initial begin
        test_reset();
        test_push();
        test_overflow_clear();
        test_underflow();
        test_reduce();
        test_dupswap();
        test_async_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pilha_rpn_n.md
# pilha_rpn_n

Parametrised RPN operand stack, the successor to the fixed two-level A/B stack. It holds DEPTH words of WIDTH bits and exposes the top two entries as the ALU operands. It executes one stack operation per clock: push, pop, reduce, clear, and optionally dup/swap. It flags overflow and underflow instead of silently corrupting state, and sits between the keypad/entry FSM and the ULA datapath.

## Interface
- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 8, number of stack entries (≥2)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- op_en  in  1  operation strobe; op is sampled only when high
- op  in  3  operation code (see Operation)
- din  in  WIDTH  data for PUSH/REDUCE
- top  out  WIDTH  entry 0 (operand B, most recent)
- next  out  WIDTH  entry 1 (operand A)
- count  out  $clog2(DEPTH+1)  number of valid entries
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- err  out  1  one-cycle pulse: the last accepted op was illegal
- err_sticky  out  1  set by any err, cleared only by CLEAR or reset

## Operation
- Storage is a shift stack, entry[0..DEPTH-1]; entry[0] is top. Entries at index ≥ count always hold zero.
- Op codes:
  - 000 NOP.
  - 001 PUSH: shift down, entry[0]=din, count+1.
  - 010 POP: shift up, zero into entry[DEPTH-1], count-1.
  - 011 REDUCE: replaces the top two with din (the ALU result); entry[0]=din, entries 2.. shift up by one, count-1.
  - 100 DUP: entry[0] copied down, count+1.
  - 101 SWAP: exchange entry[0] and entry[1].
  - 110 CLEAR: all entries zero, count=0, err_sticky=0.
  - 111 reserved, treated as NOP.
- Legality conditions:
  - PUSH needs !full.
  - POP needs count≥1.
  - REDUCE needs count≥2.
  - DUP needs count≥1 and !full.
  - SWAP needs count≥2.
- Illegal op: storage and count unchanged; err=1 for one cycle; err_sticky=1.
- CLEAR is always legal and never raises err.
- op_en=0: no state change, err=0.
- REDUCE reads din in the same cycle. The caller drives din from a combinational ULA fed by top/next.

## Timing
- Reset (rst=0, asynchronous): all entries 0, count=0, top=next=0, empty=1, full=0, err=0, err_sticky=0. Deassertion is synchronised by the surrounding design.
- Single-cycle latency: an op sampled at edge k has its results on top/next/count/flags after edge k.
- Back-to-back ops every cycle are supported; there is no busy/ready.
- empty/full are derived from registered count, so they are valid in the same cycle as count.
- err is registered and asserted in the cycle after the illegal op, aligned with the (unchanged) state.
- Reset asserted mid-sequence discards everything immediately, regardless of clk.
- DEPTH=2 degenerates to the legacy A/B stack for PUSH; REDUCE then leaves count=1.

## Configuration
- Macro: PILHA_RPN_DUPSWAP_EN.
- Defined: DUP (100) and SWAP (101) are implemented as above.
- Undefined: 100 and 101 behave as reserved. They count as illegal ops: err pulses, err_sticky sets, and state is unchanged.

## Structure
- Shared package pilha_rpn_pkg holds:
  - op code localparams: OP_NOP, OP_PUSH, OP_POP, OP_REDUCE, OP_DUP, OP_SWAP, OP_CLEAR.
  - the op width constant (3).
- Top-level holds the op decoder, legality check, count register and flag logic.
- One sub-module is natural: registrador_nb. It is a WIDTH-parameterised register with enable and async active-low reset, the generalisation of registrador8b. It is instantiated DEPTH times; a per-entry next-value mux selects hold/din/up/down/swap/zero.

## Test plan
- Reset then PUSH 0x12, PUSH 0x34 -> top=0x34, next=0x12, count=2, empty=0, err=0.
- DEPTH=4: five PUSHes 1..5 -> fifth gives err pulse, count=4, top=4, full=1, err_sticky=1; then CLEAR -> count=0, all outputs 0, err_sticky=0.
- From reset: POP -> err=1, count=0. PUSH 7, then REDUCE -> err=1, top=7, count=1.
- PUSH 3, 5, 9, then REDUCE with din=0x0E -> top=0x0E, next=3, count=2, and entry[2] reads zero after a following POP.
- With PILHA_RPN_DUPSWAP_EN: PUSH 0xA1, 0xB2, SWAP -> top=0xA1, next=0xB2; DUP -> count=3, top=next=0xA1. Without the macro: same SWAP -> err=1, top=0xB2 unchanged.
- PUSH 0x55 then assert rst between clock edges -> outputs return to reset values immediately, and a PUSH after release starts from count=0.
